// File: rtl/dp_ram_pkg.sv
// Shared definitions for the port-A arbiter of the 256x32 dual-port RAM.
package dp_ram_pkg;

    localparam int AW_DEF = 8;
    localparam int DW_DEF = 32;
    localparam int ID_W   = 1;

    // Sweep state: CLEAR owns port A, RUN hands it to the requesters.
    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    typedef logic [ID_W-1:0] req_id_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant. The grant is combinational; the pointer
// remembers which requester was served last and moves only on a grant.
module rr_arb2 (
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    // last = 1 means requester 1 was served most recently, so 0 wins a tie
    logic last;

    // Tie goes to whoever was not served last
    always_comb begin
        gnt[0] = en & req[0] & (~req[1] | last);
        gnt[1] = en & req[1] & (~req[0] | ~last);
    end

    // Pointer follows the granted index; idle cycles leave it alone
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last <= 1'b1;
        end else if (|gnt) begin
            last <= gnt[1];
        end
    end

endmodule

// File: rtl/dp_ram_arbiter.sv
// Shares RAM port A between two requesters with round-robin arbitration,
// one-cycle read responses and a clear engine that sweeps every address.
//
// Handshake: a request transfers in the cycle where reqN_valid and
// reqN_ready are both high. ready is combinational from valid and the
// arbiter state; the requester must hold valid/we/addr/wdata stable until
// it sees ready. Reads answer with rspN_valid exactly one cycle later.
module dp_ram_arbiter
    import dp_ram_pkg::*;
#(
    parameter int            AW             = AW_DEF,
    parameter int            DW             = DW_DEF,
    parameter bit            CLEAR_ON_RESET = 1'b1,
    parameter logic [DW-1:0] CLEAR_VALUE    = '0
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clr_start,
    output logic          clr_busy,
    input  logic          req0_valid,
    output logic          req0_ready,
    input  logic          req0_we,
    input  logic [AW-1:0] req0_addr,
    input  logic [DW-1:0] req0_wdata,
    input  logic          req1_valid,
    output logic          req1_ready,
    input  logic          req1_we,
    input  logic [AW-1:0] req1_addr,
    input  logic [DW-1:0] req1_wdata,
    output logic          rsp0_valid,
    output logic          rsp1_valid,
    output logic [DW-1:0] rsp_rdata,
    output logic          ram_cea,
    output logic          ram_ocea,
    output logic          ram_wrea,
    output logic [AW-1:0] ram_ada,
    output logic [DW-1:0] ram_dina,
    input  logic [DW-1:0] ram_douta,
    output state_t        dbg_state
);

    state_t        state;
    logic          boot;      // one-cycle hold-off so CLEAR starts after reset release
    logic [AW-1:0] clr_cnt;
    logic          run_en;
    logic [1:0]    gnt;
    logic          gnt_any;
    logic          sel_we;
    logic [AW-1:0] sel_addr;
    logic [DW-1:0] sel_wdata;
    logic [AW-1:0] ada_q;
    logic [DW-1:0] dina_q;
    logic          pend_v;
    req_id_t       pend_id;

    // Requests are only eligible in RUN, and never while reset is held
    assign run_en = (state == ST_RUN) && !boot && !reset;

    rr_arb2 u_arb (
        .clk   (clk),
        .reset (reset),
        .en    (run_en),
        .req   ({req1_valid, req0_valid}),
        .gnt   (gnt)
    );

    assign req0_ready = gnt[0];
    assign req1_ready = gnt[1];
    assign gnt_any    = |gnt;
    assign clr_busy   = (state == ST_CLEAR);
    assign dbg_state  = state;
    assign ram_ocea   = 1'b1;
    assign rsp_rdata  = ram_douta;
    assign rsp0_valid = pend_v && (pend_id == req_id_t'(0));
    assign rsp1_valid = pend_v && (pend_id == req_id_t'(1));

    // Pick the command of whichever requester holds the grant
    always_comb begin
        sel_we    = req0_we;
        sel_addr  = req0_addr;
        sel_wdata = req0_wdata;
        if (gnt[1]) begin
            sel_we    = req1_we;
            sel_addr  = req1_addr;
            sel_wdata = req1_wdata;
        end
    end

    // Drive port A: sweep writes in CLEAR, granted command in RUN, else idle
    // with address/data parked at their previous values
    always_comb begin
        ram_cea  = 1'b0;
        ram_wrea = 1'b0;
        ram_ada  = ada_q;
        ram_dina = dina_q;
        if (state == ST_CLEAR) begin
            ram_cea  = 1'b1;
            ram_wrea = 1'b1;
            ram_ada  = clr_cnt;
            ram_dina = CLEAR_VALUE;
        end else if (gnt_any) begin
            ram_cea  = 1'b1;
            ram_wrea = sel_we;
            ram_ada  = sel_addr;
            ram_dina = sel_wdata;
        end
    end

    // CLEAR/RUN sequencing and the sweep counter (wraps to 0 on exit)
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= ST_RUN;
            boot    <= CLEAR_ON_RESET;
            clr_cnt <= '0;
        end else if (boot) begin
            state <= ST_CLEAR;
            boot  <= 1'b0;
        end else begin
            case (state)
                ST_RUN: begin
                    if (clr_start) begin
                        state <= ST_CLEAR;
                    end
                end
                ST_CLEAR: begin
                    clr_cnt <= clr_cnt + 1'b1;
                    if (clr_cnt == {AW{1'b1}}) begin
                        state <= ST_RUN;
                    end
                end
                default: state <= ST_RUN;
            endcase
        end
    end

    // Remember the last address/data so idle cycles do not toggle the RAM bus
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ada_q  <= '0;
            dina_q <= '0;
        end else begin
            ada_q  <= ram_ada;
            dina_q <= ram_dina;
        end
    end

    // A granted read owes its requester one response pulse next cycle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pend_v  <= 1'b0;
            pend_id <= '0;
        end else begin
            pend_v  <= gnt_any && !sel_we;
            pend_id <= req_id_t'(gnt[1]);
        end
    end

endmodule
